// File: rtl/fasm_cfg_loader.sv
// fasm_cfg_loader: decodes checksummed A5/ADDR/DATA/CHK byte frames into FASM feature byte writes
module fasm_cfg_loader #(
  parameter int N_BYTES = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             I_DATA,
  input  logic                   I_VALID,
  output logic                   I_READY,
  output logic [8*N_BYTES-1:0]   O_FEAT,
  output logic                   O_DONE,
  output logic                   O_ERR
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, CHK} state_t;
  state_t st, nst;
  logic [7:0] addr, data;
  logic [CW-1:0] cnt;
  logic acc, tmo, chk_ok, wr, fin, bad;
  logic [7:0] feat [N_BYTES];
  assign I_READY = !O_DONE;
  always_comb begin
    acc = I_VALID && I_READY;
    // fire on the edge where the idle count would reach TIMEOUT
    tmo = st != IDLE && !acc && cnt == CW'(TIMEOUT - 1);
    chk_ok = (addr ^ data) == I_DATA;
    wr = st == CHK && acc && chk_ok && addr < 8'(N_BYTES);
    fin = st == CHK && acc && chk_ok && addr == 8'hFF;
    bad = tmo || (st == CHK && acc && !(wr || fin));
    nst = tmo ? IDLE : !acc ? st :
          st == IDLE ? (I_DATA == 8'hA5 ? ADDR : IDLE) :
          st == ADDR ? DATA : st == DATA ? CHK : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      addr <= '0;
      data <= '0;
      O_DONE <= 1'b0;
      O_ERR <= 1'b0;
    end else begin
      st <= nst;
      cnt <= (nst == IDLE || acc) ? '0 : cnt == CW'(TIMEOUT) ? cnt : cnt + 1'b1;
      if (acc && st == ADDR) addr <= I_DATA;
      if (acc && st == DATA) data <= I_DATA;
      if (fin) O_DONE <= 1'b1;
      if (bad) O_ERR <= 1'b1;
    end
  end
  for (genvar k = 0; k < N_BYTES; k++) begin : g_byte
    always_ff @(posedge clk) begin
      if (rst) feat[k] <= '0;
      else if (wr && addr == 8'(k)) feat[k] <= data;
    end
    assign O_FEAT[8*k +: 8] = feat[k];
  end
endmodule

// File: doc/fasm_cfg_loader.md
# fasm_cfg_loader

Configuration loader that produces the FASM feature bits consumed by configurable primitives such as bypass muxes and gates. It accepts a byte stream of checksummed write frames over a valid/ready interface and decodes each frame into a write of one feature byte. It presents the resulting feature register as a flat bus whose bits drive the select and enable inputs of FASM-annotated cells. It sits between the bitstream source and the configurable fabric, and is the producing end of the feature path those cells read.

## Interface
- `N_BYTES`, default 4: number of 8-bit feature bytes; feature bus width is 8*N_BYTES; legal range 1..254.
- `TIMEOUT`, default 255: maximum idle cycles allowed between bytes inside a frame; legal range 1..65535.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `I_DATA`, input, 8: stream byte.
- `I_VALID`, input, 1: `I_DATA` is valid.
- `I_READY`, output, 1: loader can accept a byte; a byte transfers on a cycle with `I_VALID && I_READY`.
- `O_FEAT`, output, 8*N_BYTES: feature bits; byte k is `O_FEAT[8k+7:8k]`.
- `O_DONE`, output, 1: sticky; configuration is complete.
- `O_ERR`, output, 1: sticky; at least one frame was rejected.

## Operation
- Frame format: `0xA5` header, then ADDR, then DATA, then CHK, where CHK = ADDR ^ DATA.
- FSM states: IDLE, ADDR, DATA, CHK.
  - IDLE: an accepted byte equal to `0xA5` goes to ADDR. Any other byte is discarded silently and the FSM stays in IDLE.
  - ADDR: latch the byte as addr, go to DATA.
  - DATA: latch the byte as data, go to CHK.
  - CHK: always returns to IDLE, with the action below.
- CHK actions:
  - Checksum mismatch: set `O_ERR`; no write.
  - Match, addr < N_BYTES: write data into feature byte addr.
  - Match, addr = `0xFF`: set `O_DONE`; data is ignored.
  - Match, any other addr: set `O_ERR`; no write.
- `I_READY` = !`O_DONE`. Once done, the loader accepts nothing until `rst`.
- Timeout:
  - An idle counter runs only in ADDR, DATA and CHK.
  - It clears on every accepted byte and on entering IDLE.
  - When it reaches TIMEOUT with no byte accepted, the FSM returns to IDLE, sets `O_ERR`, and drops the partial frame.
  - The counter width is sufficient for TIMEOUT; it saturates rather than wrapping.
- Rewriting a byte is allowed; the last write wins.
- `O_FEAT` never changes except by a successful write or by reset.
- Reset values: `O_FEAT` = 0 (every mux selects its default input), `O_DONE` = 0, `O_ERR` = 0, FSM in IDLE, idle counter = 0, `I_READY` = 1 from the first cycle after reset.
- Reset mid-frame discards the frame; reset after done re-enables input.

## Timing
- One byte per cycle maximum, with no bubbles required; a full frame takes at least 4 cycles.
- Write latency: a CHK byte accepted at edge n updates `O_FEAT` at edge n, so the new value is visible in the cycle after acceptance.
- `O_DONE` and `O_ERR` assert at the same edge as that write would occur.
- `I_READY` falls in the cycle after the done frame's CHK is accepted.
- `I_READY` does not depend combinationally on `I_VALID`.
- A back-to-back header may be accepted in the cycle immediately following CHK.
- Timeout fires at the edge where the counter equals TIMEOUT: with TIMEOUT=255, this is 255 idle cycles after the last accepted byte.
- `rst` has priority over every other event in the same cycle, including a CHK transfer.

## Test plan
- Reset, then frame A5 02 3C 3E → `O_FEAT[23:16]` = `0x3C`, all other bits 0, `O_ERR` = 0, `I_READY` = 1.
- Frame A5 01 0F 00 (bad checksum) → `O_FEAT` unchanged, `O_ERR` = 1; a following valid frame A5 01 0F 0E still writes byte 1 = `0x0F`.
- Garbage 11 22 then A5 00 FF FF, then A5 07 01 06 with N_BYTES=4 → byte 0 = `0xFF`, out-of-range address sets `O_ERR`, no other byte changes.
- A5 FF 00 FF → `O_DONE` = 1 and `I_READY` = 0 next cycle; further A5 00 55 55 with `I_VALID` held is not accepted and `O_FEAT` is unchanged.
- With TIMEOUT=4, send A5 03 then idle 4 cycles → FSM back in IDLE, `O_ERR` = 1; the next 03 AA A9 is discarded as garbage and byte 3 stays 0.
- Assert `rst` on the cycle a valid CHK transfers after A5 00 81 81 → `O_FEAT` = 0, `O_DONE` = 0, `O_ERR` = 0, `I_READY` = 1.
